imem_dmem_arbiter: RTL and testbench

- Shares one single-port unified memory between the RISC-V pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage.
- Arbitrates between the two requesters, with fixed data-first priority and an anti-starvation override for fetch.
- Sequences each memory transaction through a small FSM and returns responses with a one-cycle valid pulse.
- Drives stall signals back to the hazard logic, and aborts transactions that receive no acknowledge within a timeout.

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/arb_sat_counter.sv | 28 ++
 rtl/imem_dmem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int STARVE_LIM_DEF  = 4;
  localparam int TIMEOUT_LIM_DEF = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear and a compare against its limit.
module arb_sat_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data access,
// data-first with a starvation override for fetch and an ack timeout.
module imem_dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_LIM  = STARVE_LIM_DEF,
  parameter int TIMEOUT_LIM = TIMEOUT_LIM_DEF
) (
  input  logic                clk,
  input  logic                reset,
  // Handshake: a requester raises req with its fields and holds them unchanged
  // until its rvalid pulses; it must drop or replace req by the cycle after.
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err,
  output arb_state_e          dbg_state,
  output owner_e              dbg_owner,
  output logic [3:0]          dbg_starve_cnt
);

  // The timeout fires in the TIMEOUT_LIM-th ISSUE cycle, i.e. when the count
  // of completed ISSUE cycles equals TIMEOUT_LIM-1.
  localparam int TW   = (TIMEOUT_LIM < 2) ? 1 : $clog2(TIMEOUT_LIM);
  localparam int TLIM = (TIMEOUT_LIM == 0) ? 0 : TIMEOUT_LIM - 1;

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;

  logic          grant_if, grant_dm;
  logic          starve_inc, starve_clr, starve_hit;
  logic [3:0]    starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, timeout;

  arb_sat_counter #(
    .W     (4),
    .LIMIT (STARVE_LIM)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (starve_clr),
    .inc      (starve_inc),
    .cnt      (starve_cnt),
    .at_limit (starve_hit)
  );

  arb_sat_counter #(
    .W     (TW),
    .LIMIT (TLIM)
  ) u_tmo_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q != ISSUE),
    .inc      (state_q == ISSUE),
    .cnt      (tmo_cnt),
    .at_limit (tmo_hit)
  );

  // An ack arriving in the limit cycle takes precedence over the abort.
  assign timeout = (TIMEOUT_LIM != 0) && (state_q == ISSUE) && tmo_hit && !mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req && (!if_req || !starve_hit)) begin
          grant_dm   = 1'b1;
          starve_inc = if_req;
        end else if (if_req) begin
          grant_if   = 1'b1;
          starve_clr = 1'b1;
        end
        if (grant_if || grant_dm) begin
          state_d = ISSUE;
          owner_d = grant_if ? OWN_IF : OWN_DM;
        end
      end
      ISSUE: begin
        if (mem_ack || timeout) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= DATA_W'(NOP_INSTR);
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      bus_err   <= 1'b0;
      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end
      if (state_q == ISSUE) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (owner_q == OWN_IF) begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end else begin
            dm_rvalid <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end else if (timeout) begin
          mem_req <= 1'b0;
          bus_err <= 1'b1;
          if (owner_q == OWN_IF) begin
            if_rdata  <= DATA_W'(NOP_INSTR);
            if_rvalid <= 1'b1;
          end else begin
            dm_rdata  <= '0;
            dm_rvalid <= 1'b1;
          end
        end
      end
    end
  end

  assign stall_if       = if_req & ~if_rvalid;
  assign stall_mem      = dm_req & ~dm_rvalid;
  assign dbg_state      = state_q;
  assign dbg_owner      = owner_q;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: table of arbitrations plus timeout and reset sequences.
module tb_imem_dmem_arbiter;
  import riscv_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic          bus_err;
  arb_state_e    dbg_state;
  owner_e        dbg_owner;
  logic [3:0]    dbg_starve_cnt;

  always #5 clk = ~clk;

  imem_dmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_rvalid      (if_rvalid),
    .if_rdata       (if_rdata),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_be          (dm_be),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_rvalid      (dm_rvalid),
    .dm_rdata       (dm_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .stall_if       (stall_if),
    .stall_mem      (stall_mem),
    .bus_err        (bus_err),
    .dbg_state      (dbg_state),
    .dbg_owner      (dbg_owner),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] dm_exp_q[$];
  logic [DW-1:0] dm_model;

  typedef struct {
    logic          if_r;
    logic          dm_r;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] if_a;
    logic [AW-1:0] dm_a;
    logic [DW-1:0] wd;
    int            lat;
    logic [DW-1:0] rd;
    logic          if_win;
    int            starve;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid pops the oldest expected value for that port.
  always @(negedge clk) begin
    if (reset) begin
      if (if_rvalid || dm_rvalid) check("rvalid_exclusive", 32'(if_rvalid & dm_rvalid), 32'd0);
      if (if_rvalid) begin
        if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (dm_rvalid) begin
        if (dm_exp_q.size() == 0) check("dm_rvalid_unexpected", 32'(dm_rvalid), 32'd0);
        else check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
      end
    end
  end

  task automatic wait_grant(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_req && cyc < 20);
    check({name, "_grant_latency"}, cyc, 1);
  endtask

  task automatic serve(input int lat, input logic [DW-1:0] rd);
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic run_row(input vec_t v, input string name);
    int cyc;
    if_req   = v.if_r;
    if_addr  = v.if_a;
    dm_req   = v.dm_r;
    dm_we    = v.we;
    dm_be    = v.be;
    dm_addr  = v.dm_a;
    dm_wdata = v.wd;
    wait_grant(name, cyc);
    check({name, "_addr"}, mem_addr, v.if_win ? v.if_a : v.dm_a);
    check({name, "_we"}, 32'(mem_we), v.if_win ? 32'd0 : 32'(v.we));
    check({name, "_be"}, 32'(mem_be), v.if_win ? 32'hF : 32'(v.be));
    if (!v.if_win && v.we) check({name, "_wdata"}, mem_wdata, v.wd);
    check({name, "_owner"}, 32'(dbg_owner), v.if_win ? 32'(OWN_IF) : 32'(OWN_DM));
    check({name, "_starve"}, 32'(dbg_starve_cnt), v.starve);
    check({name, "_stall_if_issue"}, 32'(stall_if), 32'(v.if_r));
    check({name, "_stall_mem_issue"}, 32'(stall_mem), 32'(v.dm_r));
    if (v.if_win) if_exp_q.push_back(v.rd);
    else if (v.we) dm_exp_q.push_back(dm_model);
    else begin
      dm_exp_q.push_back(v.rd);
      dm_model = v.rd;
    end
    serve(v.lat, v.rd);
    check({name, "_done_state"}, 32'(dbg_state), 32'(DONE));
    check({name, "_mem_req_drop"}, 32'(mem_req), 32'd0);
    check({name, "_no_bus_err"}, 32'(bus_err), 32'd0);
    check({name, "_stall_if_done"}, 32'(stall_if), 32'(v.if_r && !v.if_win));
    check({name, "_stall_mem_done"}, 32'(stall_mem), 32'(v.dm_r && v.if_win));
    if (v.if_win) if_req = 1'b0;
    else dm_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hi;
    vec_t v;
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_be     = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    dm_model  = '0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0,    32'h0,        2, 32'h00500093, 1'b1, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0,   32'h2000, 32'h0,        1, 32'h11223344, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h104, 32'h2000, 32'h0,        3, 32'hCAFEF00D, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h104, 32'h0,    32'h0,        1, 32'h00A00113, 1'b1, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'h3, 32'h0,   32'h40,   32'hDEADBEEF, 2, 32'h5555AAAA, 1'b0, 0};
    for (int i = 0; i < 4; i++)
      vecs[5+i] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h3000 + 32'(4*i), 32'h0, 1,
                    32'hA0000000 + 32'(i), 1'b0, i + 1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h3010, 32'h0,        2, 32'h00000073, 1'b1, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4'hC, 32'h204, 32'h3100, 32'h0,        1, 32'h77665544, 1'b0, 1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h204, 32'h0,    32'h0,        1, 32'h00100073, 1'b1, 0};

    repeat (3) @(negedge clk);
    check("rst_mem_req_low", 32'(mem_req), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_owner", 32'(dbg_owner), 32'(OWN_NONE));
    check("rst_starve", 32'(dbg_starve_cnt), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0000_0013);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_rvalids", 32'({if_rvalid, dm_rvalid}), 32'd0);

    // Stray ack while idle must have no effect.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("stray_ack_state", 32'(dbg_state), 32'(IDLE));
    check("stray_ack_if_rdata", if_rdata, 32'h0000_0013);

    for (int i = 0; i < 12; i++) run_row(vecs[i], $sformatf("row%0d", i));
    check("store_keeps_dm_rdata", dm_rdata, 32'h00000073 ^ 32'h00000073 ^ 32'h77665544);

    // Timeout: fetch with no ack at all.
    if_req  = 1'b1;
    if_addr = 32'h300;
    wait_grant("tmo", cyc);
    if_exp_q.push_back(32'h0000_0013);
    hi = 0;
    while (mem_req && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    check("tmo_issue_cycles", hi, 16);
    check("tmo_bus_err", 32'(bus_err), 32'd1);
    check("tmo_if_rvalid", 32'(if_rvalid), 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check("tmo_bus_err_pulse", 32'(bus_err), 32'd0);
    check("tmo_back_idle", 32'(dbg_state), 32'(IDLE));

    // Ack in the limit cycle wins over the abort.
    v = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h304, 32'h0, 32'h0, 16, 32'h01234567, 1'b1, 0};
    run_row(v, "ack16");

    // Asynchronous reset in the middle of ISSUE.
    if_req  = 1'b1;
    if_addr = 32'h400;
    wait_grant("midrst", cyc);
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_if_rdata", if_rdata, 32'h0000_0013);
    check("midrst_dm_rdata", dm_rdata, 32'd0);
    dm_model = '0;
    if_req   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    v = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h500, 32'h0, 32'h0, 1, 32'h00C00193, 1'b1, 0};
    run_row(v, "post_rst_fetch");
    v = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h504, 32'h600, 32'h0, 2, 32'h0BADF00D, 1'b0, 1};
    run_row(v, "post_rst_both");

    check("if_queue_drained", if_exp_q.size(), 32'd0);
    check("dm_queue_drained", dm_exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
